// File: rtl/lcd_pattern_gen.sv
// Same-cycle RGB565 test-pattern source for the ST7789 stream engine (240x135 window).
// Define PATTERN_BTN_EN to build the debounced mode-select button.
module lcd_pattern_gen #(
  parameter int unsigned H_ACTIVE        = 240,
  parameter int unsigned V_ACTIVE        = 135,
  parameter int unsigned FRAME_PIXELS    = 32400,
  parameter int unsigned BAR_WIDTH       = 30,
  parameter logic [1:0]  DEFAULT_MODE    = 2'd0,
  parameter logic [15:0] SOLID_COLOR     = 16'h001F,
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] pixel_cnt,
  input  logic        btn_n,
  output logic [15:0] pixel,
  output logic [1:0]  mode,
  output logic        frame_done,
  output logic        sync_err
);

  localparam int unsigned X_W   = ($clog2(H_ACTIVE) < 8) ? 8 : $clog2(H_ACTIVE);
  localparam int unsigned Y_W   = ($clog2(V_ACTIVE + 1) < 8) ? 8 : $clog2(V_ACTIVE + 1);
  localparam int unsigned BC_W  = (BAR_WIDTH < 2) ? 1 : $clog2(BAR_WIDTH);
  localparam int unsigned BAR_W = 3;
  localparam logic [15:0] FRAME_END = 16'(FRAME_PIXELS);

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [BAR_W-1:0] bar;
    logic [BC_W-1:0]  bcol;
  } coord_t;

  // Raster-order step: column-in-bar, bar, x, then y on row wrap.
  function automatic coord_t coord_inc(input coord_t c);
    coord_t n;
    n = c;
    if (c.x == X_W'(H_ACTIVE - 1)) begin
      n.x    = '0;
      n.y    = c.y + Y_W'(1);
      n.bar  = '0;
      n.bcol = '0;
    end else begin
      n.x = c.x + X_W'(1);
      if (c.bcol == BC_W'(BAR_WIDTH - 1)) begin
        n.bcol = '0;
        n.bar  = c.bar + BAR_W'(1);
      end else begin
        n.bcol = c.bcol + BC_W'(1);
      end
    end
    return n;
  endfunction

  // Pattern colour; coordinates past the window (the index after the last pixel) give black.
  function automatic logic [15:0] colour(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                         input logic [BAR_W-1:0] bar, input logic [1:0] m);
    logic [15:0] px;
    px = 16'h0000;
    if ((y < Y_W'(V_ACTIVE)) && (x < X_W'(H_ACTIVE))) begin
      unique case (m)
        2'd0: begin
          case (bar)
            3'd0:    px = 16'hFFFF;
            3'd1:    px = 16'hFFE0;
            3'd2:    px = 16'h07FF;
            3'd3:    px = 16'h07E0;
            3'd4:    px = 16'hF81F;
            3'd5:    px = 16'hF800;
            3'd6:    px = 16'h001F;
            default: px = 16'h0000;
          endcase
        end
        2'd1:    px = (x[4] ^ y[4]) ? 16'hFFFF : 16'h0000;
        2'd2:    px = {x[7:3], y[7:2], 5'b00000};
        default: px = SOLID_COLOR;
      endcase
    end
    return px;
  endfunction

  localparam coord_t      ORIGIN   = '0;
  localparam coord_t      COORD1   = coord_inc(ORIGIN);
  localparam logic [15:0] RST_CUR  = colour(ORIGIN.x, ORIGIN.y, ORIGIN.bar, DEFAULT_MODE);
  localparam logic [15:0] RST_NEXT = colour(COORD1.x, COORD1.y, COORD1.bar, DEFAULT_MODE);

  logic [1:0] mode_pend;

`ifdef PATTERN_BTN_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]      btn_sync_q;
  logic            btn_last_q;
  logic            btn_stable_q;
  logic [DB_W-1:0] db_cnt_q;
  logic [1:0]      mode_pend_q;

  // Synchronise, require DEBOUNCE_CYCLES of unchanged level, count accepted presses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_sync_q   <= 2'b11;
      btn_last_q   <= 1'b1;
      btn_stable_q <= 1'b1;
      db_cnt_q     <= '0;
      mode_pend_q  <= DEFAULT_MODE;
    end else begin
      btn_sync_q <= {btn_sync_q[0], btn_n};
      btn_last_q <= btn_sync_q[1];
      if (btn_sync_q[1] != btn_last_q) begin
        db_cnt_q <= '0;
      end else if (btn_sync_q[1] != btn_stable_q) begin
        if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt_q     <= '0;
          btn_stable_q <= btn_sync_q[1];
          if (!btn_sync_q[1]) mode_pend_q <= mode_pend_q + 2'd1;
        end else begin
          db_cnt_q <= db_cnt_q + DB_W'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  assign mode_pend = mode_pend_q;
`else
  logic unused_btn;
  assign unused_btn = btn_n;
  assign mode_pend  = DEFAULT_MODE;
`endif

  logic [15:0] cnt_q, cnt_d;
  coord_t      nx_q, nx_d, nx2;
  logic [15:0] pix_cur_q, pix_cur_d;
  logic [15:0] pix_next_q, pix_next_d;
  logic [1:0]  mode_q, mode_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        done_seen_q, done_seen_d;

  logic [15:0] cnt_p1;
  logic        hit_cur, hit_next, hit_zero;

  assign cnt_p1   = cnt_q + 16'd1;
  assign hit_cur  = (pixel_cnt == cnt_q);
  assign hit_next = (pixel_cnt == cnt_p1);
  assign hit_zero = (pixel_cnt == 16'd0);

  // nx_q tracks the coordinates of cnt_q+1, so advancing needs only one more step.
  always_comb begin
    cnt_d       = cnt_q;
    nx_d        = nx_q;
    pix_cur_d   = pix_cur_q;
    pix_next_d  = pix_next_q;
    mode_d      = mode_q;
    err_d       = err_q;
    done_d      = 1'b0;
    done_seen_d = done_seen_q;
    nx2         = coord_inc(nx_q);

    if (!hit_cur) begin
      if (hit_next) begin
        if (cnt_p1 < FRAME_END) begin
          cnt_d      = cnt_p1;
          nx_d       = nx2;
          pix_cur_d  = pix_next_q;
          pix_next_d = colour(nx2.x, nx2.y, nx2.bar, mode_q);
        end
      end else if (hit_zero) begin
        mode_d      = mode_pend;
        cnt_d       = '0;
        nx_d        = COORD1;
        pix_cur_d   = colour(ORIGIN.x, ORIGIN.y, ORIGIN.bar, mode_pend);
        pix_next_d  = colour(COORD1.x, COORD1.y, COORD1.bar, mode_pend);
        done_seen_d = 1'b0;
      end else if (pixel_cnt < FRAME_END) begin
        err_d = 1'b1;
      end
    end

    if ((pixel_cnt == FRAME_END) && !done_seen_q) begin
      done_d      = 1'b1;
      done_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= '0;
      nx_q        <= COORD1;
      pix_cur_q   <= RST_CUR;
      pix_next_q  <= RST_NEXT;
      mode_q      <= DEFAULT_MODE;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      done_seen_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      nx_q        <= nx_d;
      pix_cur_q   <= pix_cur_d;
      pix_next_q  <= pix_next_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      done_q      <= done_d;
      done_seen_q <= done_seen_d;
    end
  end

  // Zero-latency pixel select; index 0 is served from a constant on the first restart cycle.
  always_comb begin
    pixel = 16'h0000;
    if (hit_cur)        pixel = pix_cur_q;
    else if (hit_next)  pixel = pix_next_q;
    else if (hit_zero)  pixel = colour(ORIGIN.x, ORIGIN.y, ORIGIN.bar, mode_q);
  end

  assign mode       = mode_q;
  assign frame_done = done_q;
  assign sync_err   = err_q;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Randomised bench for lcd_pattern_gen: four instances (DEFAULT_MODE 0..3) share one index
// stream and are checked every cycle against an arithmetic raster model.
module tb_lcd_pattern_gen;

  localparam int FRAME = 32400;
  localparam int DEB   = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] pixel_cnt;
  logic        btn_n;
  logic [15:0] pix [4];
  logic [1:0]  md  [4];
  logic        fd  [4];
  logic        se  [4];

  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt;
  int m_mode [4];
  int m_pend [4];
  bit m_err, m_seen, m_fd;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    lcd_pattern_gen #(
      .DEFAULT_MODE   (2'(g)),
      .DEBOUNCE_CYCLES(DEB)
    ) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .pixel_cnt (pixel_cnt),
      .btn_n     (btn_n),
      .pixel     (pix[g]),
      .mode      (md[g]),
      .frame_done(fd[g]),
      .sync_err  (se[g])
    );
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, got, exp, $time);
      if (n_fail >= 200) begin
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
      end
    end
  endtask

  function automatic logic [15:0] colour_ref(input int idx, input int m);
    int x, y;
    if (idx >= FRAME) return 16'h0000;
    x = idx % 240;
    y = idx / 240;
    case (m)
      0: begin
        case (x / 30)
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      1: return (((x / 16) % 2) != ((y / 16) % 2)) ? 16'hFFFF : 16'h0000;
      2: return 16'((x / 8) * 2048 + (y / 4) * 32);
      default: return 16'h001F;
    endcase
  endfunction

  function automatic logic [15:0] exp_pixel(input int pc, input int i);
    if (pc == m_cnt || pc == m_cnt + 1) return colour_ref(pc, m_mode[i]);
    if (pc == 0) return colour_ref(0, m_mode[i]);
    return 16'h0000;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_err = 0; m_seen = 0; m_fd = 0;
    for (int i = 0; i < 4; i++) begin
      m_mode[i] = i;
      m_pend[i] = i;
    end
  endtask

  task automatic model_step(input int pc);
    if (pc == m_cnt) begin
    end else if (pc == m_cnt + 1) begin
      if (pc < FRAME) m_cnt = pc;
    end else if (pc == 0) begin
      m_cnt  = 0;
      m_seen = 0;
      for (int i = 0; i < 4; i++) m_mode[i] = m_pend[i];
    end else if (pc < FRAME) begin
      m_err = 1;
    end
    m_fd = (pc == FRAME) && !m_seen;
    if (m_fd) m_seen = 1;
  endtask

  // Entered and left at posedge+1: drive, check mid-cycle, then advance the model.
  task automatic cycle(input int pc, input logic btn);
    pixel_cnt = 16'(pc);
    btn_n     = btn;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("pixel", pix[i], exp_pixel(pc, i));
      check("mode", 16'(md[i]), 16'(m_mode[i]));
      check("frame_done", 16'(fd[i]), 16'(m_fd));
      check("sync_err", 16'(se[i]), 16'(m_err));
    end
    @(posedge clk);
    model_step(pc);
    #1;
  endtask

  task automatic hold(input int pc, input int n);
    for (int k = 0; k < n; k++) cycle(pc, 1'b1);
  endtask

  task automatic run_to(input int last, input int gap_max);
    for (int p = 1; p <= last; p++) hold(p, $urandom_range(2, gap_max));
  endtask

  task automatic press(input int pc);
    for (int k = 0; k < DEB + 10; k++) cycle(pc, 1'b0);
    for (int k = 0; k < DEB + 10; k++) cycle(pc, 1'b1);
`ifdef PATTERN_BTN_EN
    for (int i = 0; i < 4; i++) m_pend[i] = (m_pend[i] + 1) % 4;
`endif
  endtask

  task automatic glitch(input int pc);
    for (int k = 0; k < DEB / 3; k++) cycle(pc, 1'b0);
    for (int k = 0; k < DEB + 10; k++) cycle(pc, 1'b1);
  endtask

  initial begin
    int n, sel, jmp;
    resetn    = 1'b0;
    pixel_cnt = 16'd0;
    btn_n     = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    hold(0, 4);

    // Full frame at the maximum rate, with a press and a short glitch mid-frame.
    for (int p = 1; p <= FRAME; p++) begin
      hold(p, 2);
      if (p == 10000) begin
        press(p);
        glitch(p);
      end
    end
    hold(FRAME, 5);
    hold(0, 4);

    // Out-of-sequence index at cnt 100, then restart; the error flag must stay set.
    run_to(100, 2);
    hold(500, 3);
    hold(0, 3);
    run_to(3, 2);

    // Random bursts: partial frames ended by restart, random jump, early frame end or a press.
    repeat (14) begin
      hold(0, 3);
      n = $urandom_range(5, 150);
      run_to(n, 3);
      sel = $urandom_range(0, 3);
      case (sel)
        0: hold(0, 2);
        1: begin
          jmp = $urandom_range(0, 40000);
          hold(jmp, 3);
        end
        2: hold(FRAME, 3);
        default: press(n);
      endcase
    end

    // Asynchronous reset mid-frame.
    hold(0, 3);
    run_to(5000, 2);
    #3 resetn = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rst_pixel_5000", pix[i], 16'h0000);
      check("rst_mode", 16'(md[i]), 16'(i));
      check("rst_frame_done", 16'(fd[i]), 16'h0000);
      check("rst_sync_err", 16'(se[i]), 16'h0000);
    end
    pixel_cnt = 16'd0;
    #1;
    for (int i = 0; i < 4; i++) check("rst_pixel_0", pix[i], colour_ref(0, i));
    model_reset();
    @(posedge clk);
    #1 resetn = 1'b1;
    hold(0, 3);
    run_to(60, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
